// File: rtl/dma_read_arbiter.sv
// -----------------------------------------------------------------------------
// dma_read_arbiter
//
// Shares one DMA read port (addr/read/word/valid level handshake) between
// NUM_REQ requesters. Requests are served one at a time in round-robin order.
// The returned word goes only to the granted requester. ram_read is always
// low for at least one cycle between two transactions.
//
// Optional feature (compile-time macro DMA_ARB_TIMEOUT_EN):
//   Aborts a WAIT that lasts TIMEOUT_CYCLES cycles. The requester then gets
//   req_word = all ones, and the sticky flag timeout_err is set.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   req_addr      packed requester addresses, slice i = [i*RAM_WID +: RAM_WID]
//   req_read      per-requester read request (level)
//   req_word      returned word (shared, qualified by req_valid)
//   req_valid     per-requester completion, at most one bit high
//   ram_dma_addr  registered DMA address
//   ram_read      DMA read request
//   ram_word      DMA data
//   ram_valid     DMA data valid
//   grant         index of the current / last granted requester
//   busy          high whenever the arbiter is not idle
//   timeout_err   sticky timeout flag (only with DMA_ARB_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module dma_read_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int RAM_WID          = 32,
    parameter int RAM_WORD_WID     = 16,
    parameter int TIMEOUT_CYCLES   = 255,
    parameter int TIMEOUT_CNTR_LEN = 8,
    localparam int GW              = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
`ifdef DMA_ARB_TIMEOUT_EN
    output logic                        timeout_err,
`endif
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ*RAM_WID-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]          req_read,
    output logic [RAM_WORD_WID-1:0]     req_word,
    output logic [NUM_REQ-1:0]          req_valid,
    output logic [RAM_WID-1:0]          ram_dma_addr,
    output logic                        ram_read,
    input  logic [RAM_WORD_WID-1:0]     ram_word,
    input  logic                        ram_valid,
    output logic [GW-1:0]               grant,
    output logic                        busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    localparam logic [GW:0] NUM_REQ_W = (GW+1)'(NUM_REQ);

    state_t                  r_state;
    logic [GW-1:0]           r_last_grant;
    logic [GW-1:0]           r_grant;
    logic                    r_ram_read;
    logic [RAM_WID-1:0]      r_ram_dma_addr;
    logic [RAM_WORD_WID-1:0] r_req_word;
    logic [NUM_REQ-1:0]      r_req_valid;

    logic [RAM_WID-1:0]      w_addr_arr [NUM_REQ];
    logic [GW-1:0]           w_cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]      w_cand_ok;
    logic [NUM_REQ-1:0]      w_eligible;
    logic [NUM_REQ-1:0]      w_grant_onehot;
    logic                    w_pick_found;
    logic [GW-1:0]           w_pick_idx;
    logic                    w_grant_read;

    // Out-of-range parameter settings leave this marker block in the hierarchy.
    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CNTR_LEN < 1) begin : g_unsupported_params
    end

    assign w_eligible   = req_read & ~r_req_valid;
    assign w_grant_read = req_read[r_grant];

    // Candidate gi is the requester (gi+1) places after the last grant,
    // wrapped modulo NUM_REQ. Candidate 0 therefore has the highest priority.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        localparam logic [GW:0] OFFS = (GW+1)'(gi + 1);
        logic [GW:0] w_sum;

        assign w_addr_arr[gi]     = req_addr[gi*RAM_WID +: RAM_WID];
        assign w_sum              = {1'b0, r_last_grant} + OFFS;
        assign w_cand_idx[gi]     = (w_sum >= NUM_REQ_W) ? GW'(w_sum - NUM_REQ_W) : GW'(w_sum);
        assign w_cand_ok[gi]      = w_eligible[w_cand_idx[gi]];
        assign w_grant_onehot[gi] = (r_grant == GW'(gi));
    end

    // Scan from the lowest priority upward, so the highest priority
    // (lowest offset) eligible candidate is the last one written.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = w_cand_idx[0];
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_cand_ok[k]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand_idx[k];
            end
        end
    end

`ifdef DMA_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_CNTR_LEN-1:0] TMO_LAST = TIMEOUT_CNTR_LEN'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_CNTR_LEN-1:0] r_to_cnt;
    logic                        r_timeout_err;
    assign timeout_err = r_timeout_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_last_grant   <= GW'(NUM_REQ - 1);
            r_grant        <= '0;
            r_ram_read     <= 1'b0;
            r_ram_dma_addr <= '0;
            r_req_word     <= '0;
            r_req_valid    <= '0;
`ifdef DMA_ARB_TIMEOUT_EN
            r_to_cnt       <= '0;
            r_timeout_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A valid still high from the previous transaction
                    // must not complete the next one, so hold off the grant.
                    if (w_pick_found && !ram_valid) begin
                        r_ram_dma_addr <= w_addr_arr[w_pick_idx];
                        r_ram_read     <= 1'b1;
                        r_grant        <= w_pick_idx;
                        r_state        <= ST_WAIT;
`ifdef DMA_ARB_TIMEOUT_EN
                        r_to_cnt       <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    // Data wins over a simultaneous abort.
                    if (ram_valid) begin
                        r_req_word  <= ram_word;
                        r_req_valid <= w_grant_onehot;
                        r_ram_read  <= 1'b0;
                        r_state     <= ST_DONE;
                    end else if (!w_grant_read) begin
                        r_ram_read   <= 1'b0;
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end
`ifdef DMA_ARB_TIMEOUT_EN
                    else if (r_to_cnt == TMO_LAST) begin
                        r_ram_read    <= 1'b0;
                        r_req_word    <= '1;
                        r_req_valid   <= w_grant_onehot;
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    if (!w_grant_read) begin
                        r_req_valid  <= '0;
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_word     = r_req_word;
    assign req_valid    = r_req_valid;
    assign ram_dma_addr = r_ram_dma_addr;
    assign ram_read     = r_ram_read;
    assign grant        = r_grant;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dma_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_read_arbiter
//
// Directed scenarios, followed by a randomized run of requesters and DMA.
// Every cycle the DUT outputs are compared against a transaction-level
// reference model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_dma_read_arbiter;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 16;
    localparam int TMO = 20;
    localparam int GW  = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_read;
    logic [DW-1:0]     req_word;
    logic [N-1:0]      req_valid;
    logic [AW-1:0]     ram_dma_addr;
    logic              ram_read;
    logic [DW-1:0]     ram_word;
    logic              ram_valid;
    logic [GW-1:0]     grant;
    logic              busy;
`ifdef DMA_ARB_TIMEOUT_EN
    logic              timeout_err;
`endif

    always #5 clk = ~clk;

    dma_read_arbiter #(
        .NUM_REQ(N), .RAM_WID(AW), .RAM_WORD_WID(DW),
        .TIMEOUT_CYCLES(TMO), .TIMEOUT_CNTR_LEN(8)
    ) u_dut (
`ifdef DMA_ARB_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .clk         (clk),
        .rst         (rst),
        .req_addr    (req_addr),
        .req_read    (req_read),
        .req_word    (req_word),
        .req_valid   (req_valid),
        .ram_dma_addr(ram_dma_addr),
        .ram_read    (ram_read),
        .ram_word    (ram_word),
        .ram_valid   (ram_valid),
        .grant       (grant),
        .busy        (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model. The phase is 0 = idle, 1 = read outstanding, 2 = word delivered.
    int            m_phase = 0;
    int            m_last  = N - 1;
    int            m_grant = 0;
    int            m_n     = 0;
    bit            m_ram_read = 0;
    bit            m_tmo   = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_word  = '0;
    logic [N-1:0]  m_valid = '0;

    task automatic model_step();
        int  pick;
        bit  found;
        if (rst) begin
            m_phase = 0; m_last = N - 1; m_grant = 0; m_n = 0;
            m_ram_read = 0; m_tmo = 0; m_addr = '0; m_word = '0; m_valid = '0;
        end else if (m_phase == 0) begin
            found = 0;
            pick  = 0;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (!found && req_read[idx] && !m_valid[idx]) begin
                    found = 1;
                    pick  = idx;
                end
            end
            if (found && !ram_valid) begin
                m_addr     = req_addr[pick*AW +: AW];
                m_ram_read = 1;
                m_grant    = pick;
                m_phase    = 1;
                m_n        = 0;
            end
        end else if (m_phase == 1) begin
            if (ram_valid) begin
                m_word = ram_word;
                m_valid = '0;
                m_valid[m_grant] = 1'b1;
                m_ram_read = 0;
                m_phase = 2;
            end else if (!req_read[m_grant]) begin
                m_ram_read = 0;
                m_last = m_grant;
                m_phase = 0;
            end
`ifdef DMA_ARB_TIMEOUT_EN
            else begin
                m_n++;
                if (m_n == TMO) begin
                    m_ram_read = 0;
                    m_word = '1;
                    m_valid = '0;
                    m_valid[m_grant] = 1'b1;
                    m_tmo = 1;
                    m_phase = 2;
                end
            end
`endif
        end else begin
            if (!req_read[m_grant]) begin
                m_valid = '0;
                m_last = m_grant;
                m_phase = 0;
            end
        end
    endtask

    task automatic compare();
        check_val("ram_read", ram_read, m_ram_read);
        check_val("ram_dma_addr", ram_dma_addr, m_addr);
        check_val("req_valid", req_valid, m_valid);
        check_val("req_word", req_word, m_word);
        check_val("grant", grant, m_grant);
        check_val("busy", busy, (m_phase != 0));
        check_val("valid_onehot", ($countones(req_valid) <= 1), 1);
`ifdef DMA_ARB_TIMEOUT_EN
        check_val("timeout_err", timeout_err, m_tmo);
`endif
    endtask

    // One clock: the model sees the same inputs the DUT samples, and the
    // outputs are checked just after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic set_req(input int i, input bit rd, input logic [AW-1:0] a);
        req_read[i] = rd;
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ram_valid = 1'b0;
        req_read = '0;
        tick();
        rst = 1'b0;
    endtask

    // Wait for a read, answer it after a short delay, and release the winner.
    task automatic serve_one(output int who);
        int guard;
        guard = 0;
        who = -1;
        while (!ram_read && guard < 50) begin
            tick();
            guard++;
        end
        check_val("serve_start", ram_read, 1);
        if (!ram_read) return;
        repeat ($urandom_range(0, 5)) tick();
        ram_valid = 1'b1;
        ram_word = DW'($urandom);
        tick();
        ram_valid = 1'b0;
        who = int'(grant);
        for (int i = 0; i < N; i++) if (req_valid[i]) req_read[i] = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1);
    end

    initial begin
        int who;
        int dma_cnt;
        rst = 1'b1; req_addr = '0; req_read = '0; ram_word = '0; ram_valid = 1'b0;
        tick(); tick();
        check_val("rst_busy", busy, 0);
        rst = 1'b0;

        // Single read with a 12-cycle DMA delay.
        set_req(0, 1, 32'h12340);
        tick();
        check_val("single_rd_lat", ram_read, 1);
        check_val("single_addr", ram_dma_addr, 32'h12340);
        set_req(0, 1, 32'h0BAD0);          // address changes must be ignored in WAIT
        repeat (11) tick();
        check_val("single_addr_hold", ram_dma_addr, 32'h12340);
        ram_valid = 1'b1; ram_word = 16'hBEEF;
        tick();
        ram_valid = 1'b0;
        check_val("single_valid", req_valid, 2'b01);
        check_val("single_word", req_word, 16'hBEEF);
        check_val("single_rr_low", ram_read, 0);
        req_read[0] = 1'b0;
        tick(); tick();

        // Contention: three pairs of simultaneous requests.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            set_req(0, 1, 32'h12340);
            set_req(1, 1, 32'h12342);
            serve_one(who);
            check_val("cont_first", who, 0);
            serve_one(who);
            check_val("cont_second", who, 1);
        end

        // Abort by requester 1 while requester 0 waits, with a stale valid.
        do_reset();
        set_req(0, 1, 32'h00AA0);
        set_req(1, 1, 32'h00BB0);
        req_read[0] = 1'b0;
        tick();
        check_val("abort_grant1", grant, 1);
        req_read[0] = 1'b1;
        repeat (2) tick();
        req_read[1] = 1'b0;
        tick();
        check_val("abort_rr_low", ram_read, 0);
        check_val("abort_no_valid", req_valid, 0);
        check_val("abort_idle", busy, 0);
        ram_valid = 1'b1;
        tick();
        check_val("stale_block", ram_read, 0);
        ram_valid = 1'b0;
        tick();
        check_val("abort_regrant", grant, 0);
        check_val("abort_regrant_addr", ram_dma_addr, 32'h00AA0);

        // Data and abort in the same cycle: data wins.
        tick();
        ram_valid = 1'b1; ram_word = 16'h5A5A; req_read[0] = 1'b0;
        tick();
        ram_valid = 1'b0;
        check_val("race_valid", req_valid, 2'b01);
        check_val("race_word", req_word, 16'h5A5A);
        tick();

        // Reset in the middle of WAIT.
        set_req(1, 1, 32'h00CC0);
        tick(); tick();
        rst = 1'b1; req_read = '0;
        tick();
        rst = 1'b0;
        check_val("rstw_rr", ram_read, 0);
        check_val("rstw_busy", busy, 0);
        check_val("rstw_valid", req_valid, 0);
        req_read = '1;
        tick();
        check_val("rstw_grant0", grant, 0);
        serve_one(who);
        serve_one(who);
        check_val("rstw_then1", who, 1);

`ifdef DMA_ARB_TIMEOUT_EN
        do_reset();
        set_req(0, 1, 32'h00DD0);
        tick();
        repeat (TMO - 1) tick();
        check_val("tmo_not_yet", req_valid, 0);
        tick();
        check_val("tmo_valid", req_valid, 2'b01);
        check_val("tmo_word", req_word, 16'hFFFF);
        check_val("tmo_err", timeout_err, 1);
        req_read[0] = 1'b0;
        repeat (4) tick();
        check_val("tmo_sticky", timeout_err, 1);
        do_reset();
        check_val("tmo_clr", timeout_err, 0);
`endif

        // Randomized traffic.
        dma_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            ram_valid = 1'b0;
            if (ram_read) begin
                if (dma_cnt == 0) begin
                    ram_valid = 1'b1;
                    ram_word = DW'($urandom);
                    dma_cnt = $urandom_range(0, 12);
                end else begin
                    dma_cnt--;
                end
            end else if ($urandom_range(0, 31) == 0) begin
                ram_valid = 1'b1;
                ram_word = DW'($urandom);
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    if ($urandom_range(0, 3) != 0) req_read[i] = 1'b0;
                end else if (req_read[i]) begin
                    if ($urandom_range(0, 63) == 0) req_read[i] = 1'b0;
                    else if ($urandom_range(0, 7) == 0) req_addr[i*AW +: AW] = $urandom;
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(i, 1, $urandom);
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
